// File: rtl/instr_decode_queue_if.sv
// Handshake bundle between fetch, the instruction decode queue and the control stage.
// IllegalOp exists only when DECODER_ILLEGAL_OP_EN is defined.
interface instr_decode_queue_if #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int FIELD_W = 4,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     InValid;
  logic                     InReady;
  logic [INSTR_W-1:0]       Instr;
  logic                     Flush;
  logic                     OutValid;
  logic                     OutReady;
  logic [OPC_W-1:0]         OpCode;
  logic [FIELD_W-1:0]       OpC;
  logic [FIELD_W-1:0]       OpB;
  logic [FIELD_W-1:0]       OpA;
  logic [INSTR_W-OPC_W-1:0] AddrImm;
  logic [CNT_W-1:0]         Count;
`ifdef DECODER_ILLEGAL_OP_EN
  logic                     IllegalOp;
`endif

  // Queue side
  modport slave (
    input  InValid, Instr, Flush, OutReady,
    output InReady, OutValid, OpCode, OpC, OpB, OpA, AddrImm, Count
`ifdef DECODER_ILLEGAL_OP_EN
    , output IllegalOp
`endif
  );

  // Fetch/consumer side
  modport master (
    output InValid, Instr, Flush, OutReady,
    input  InReady, OutValid, OpCode, OpC, OpB, OpA, AddrImm, Count
`ifdef DECODER_ILLEGAL_OP_EN
    , input IllegalOp
`endif
  );
endinterface

// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction FIFO presenting the head word split into decode fields.
// Optional illegal-opcode flag enabled by defining DECODER_ILLEGAL_OP_EN.
module instr_decode_queue #(
  parameter int                  INSTR_W      = 16,
  parameter int                  OPC_W        = 4,
  parameter int                  FIELD_W      = 4,
  parameter int                  DEPTH        = 4,
  parameter logic [2**OPC_W-1:0] ILLEGAL_MASK = '0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  instr_decode_queue_if.slave  bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ADDR_W = INSTR_W - OPC_W;

  if (INSTR_W != OPC_W + 3 * FIELD_W) begin : g_bad_width
    $error("instr_decode_queue: INSTR_W must equal OPC_W + 3*FIELD_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_decode_queue: DEPTH must be a power of two >= 2");
  end
  if ($bits(ILLEGAL_MASK) != 2 ** OPC_W) begin : g_bad_mask
    $error("instr_decode_queue: ILLEGAL_MASK needs one bit per opcode");
  end

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] w_head;
  logic [INSTR_W-1:0] w_fields;

  // Ready depends only on stored occupancy, never on OutReady.
  assign w_in_ready  = (r_count != CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.InValid & w_in_ready;
  assign w_pop       = w_out_valid & bus.OutReady;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.Flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (w_push && !bus.Flush) r_mem[r_wr_ptr] <= bus.Instr;
  end

  assign w_head   = r_mem[r_rd_ptr];
  assign w_fields = w_out_valid ? w_head : '0;

  assign bus.InReady  = w_in_ready;
  assign bus.OutValid = w_out_valid;
  assign bus.Count    = r_count;
  assign bus.OpCode   = w_fields[INSTR_W-1 -: OPC_W];
  assign bus.OpC      = w_fields[INSTR_W-OPC_W-1 -: FIELD_W];
  assign bus.OpB      = w_fields[2*FIELD_W-1 -: FIELD_W];
  assign bus.OpA      = w_fields[FIELD_W-1:0];
  assign bus.AddrImm  = w_fields[ADDR_W-1:0];

`ifdef DECODER_ILLEGAL_OP_EN
  assign bus.IllegalOp = w_out_valid & ILLEGAL_MASK[w_fields[INSTR_W-1 -: OPC_W]];
`endif
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed self-checking bench for instr_decode_queue (default parameters).
module tb_instr_decode_queue;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  instr_decode_queue_if #(.INSTR_W(16), .OPC_W(4), .FIELD_W(4), .DEPTH(4)) bus ();

  instr_decode_queue #(
    .INSTR_W(16), .OPC_W(4), .FIELD_W(4), .DEPTH(4), .ILLEGAL_MASK(16'h8001)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      $display("[TB] %s: observed %0h expected %0h", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] w;
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.InValid  = 1'b0;
    bus.Instr    = '0;
    bus.Flush    = 1'b0;
    bus.OutReady = 1'b0;
    tick();
    tick();
    chk("rst_count",    32'(bus.Count),    32'd0);
    chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("rst_inready",  32'(bus.InReady),  32'd1);
    chk("rst_opcode",   32'(bus.OpCode),   32'd0);
    chk("rst_addrimm",  32'(bus.AddrImm),  32'd0);
`ifdef DECODER_ILLEGAL_OP_EN
    chk("rst_illegal",  32'(bus.IllegalOp), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single transfer
    bus.InValid = 1'b1;
    bus.Instr   = 16'hA3C5;
    tick();
    bus.InValid = 1'b0;
    chk("single_valid",  32'(bus.OutValid), 32'd1);
    chk("single_opcode", 32'(bus.OpCode),   32'hA);
    chk("single_opc",    32'(bus.OpC),      32'h3);
    chk("single_opb",    32'(bus.OpB),      32'hC);
    chk("single_opa",    32'(bus.OpA),      32'h5);
    chk("single_addr",   32'(bus.AddrImm),  32'h3C5);
    chk("single_count",  32'(bus.Count),    32'd1);
    tick();
    chk("hold_opcode",   32'(bus.OpCode),   32'hA);
    chk("hold_addr",     32'(bus.AddrImm),  32'h3C5);
    chk("hold_count",    32'(bus.Count),    32'd1);
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
    chk("pop_count",  32'(bus.Count),    32'd0);
    chk("pop_valid",  32'(bus.OutValid), 32'd0);
    chk("pop_opcode", 32'(bus.OpCode),   32'd0);
    chk("pop_addr",   32'(bus.AddrImm),  32'd0);

    // Fill to full; fifth word must be refused
    for (int i = 1; i <= 5; i++) begin
      w = 16'(i) << 12;
      bus.InValid = 1'b1;
      bus.Instr   = w;
      tick();
      if (i == 4) begin
        chk("full_count",   32'(bus.Count),   32'd4);
        chk("full_inready", 32'(bus.InReady), 32'd0);
      end
    end
    bus.InValid = 1'b0;
    chk("full_count_after5", 32'(bus.Count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_opcode%0d", i), 32'(bus.OpCode), 32'(i));
      bus.OutReady = 1'b1;
      tick();
    end
    bus.OutReady = 1'b0;
    chk("drain_count", 32'(bus.Count), 32'd0);

    // Simultaneous push/pop at Count=2 across pointer wrap
    bus.InValid = 1'b1;
    bus.Instr   = 16'h6000;
    tick();
    bus.Instr   = 16'h7000;
    tick();
    chk("pp_count_start", 32'(bus.Count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      w = 16'(8 + i) << 12;
      bus.Instr    = w;
      bus.OutReady = 1'b1;
      chk($sformatf("pp_opcode%0d", i), 32'(bus.OpCode), 32'(6 + i));
      tick();
      chk($sformatf("pp_count%0d", i), 32'(bus.Count), 32'd2);
    end
    bus.InValid = 1'b0;
    chk("pp_tail0", 32'(bus.OpCode), 32'd14);
    tick();
    chk("pp_tail1", 32'(bus.OpCode), 32'd15);
    tick();
    bus.OutReady = 1'b0;
    chk("pp_empty", 32'(bus.Count), 32'd0);

    // Flush overrides a concurrent push
    bus.InValid = 1'b1;
    bus.Instr   = 16'h1AAA; tick();
    bus.Instr   = 16'h2BBB; tick();
    bus.Instr   = 16'h3CCC; tick();
    chk("fl_pre_count", 32'(bus.Count), 32'd3);
    bus.Instr = 16'h7777;
    bus.Flush = 1'b1;
    tick();
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    chk("fl_count",   32'(bus.Count),    32'd0);
    chk("fl_valid",   32'(bus.OutValid), 32'd0);
    chk("fl_opcode",  32'(bus.OpCode),   32'd0);
    chk("fl_addr",    32'(bus.AddrImm),  32'd0);
    chk("fl_inready", 32'(bus.InReady),  32'd1);
    tick();
    chk("fl_no7777", 32'(bus.OutValid), 32'd0);

    // Asynchronous reset between edges
    bus.InValid = 1'b1;
    bus.Instr   = 16'h1111; tick();
    bus.Instr   = 16'h2222; tick();
    bus.Instr   = 16'h3333; tick();
    bus.InValid = 1'b0;
    chk("ar_pre_count", 32'(bus.Count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_count",   32'(bus.Count),    32'd0);
    chk("ar_valid",   32'(bus.OutValid), 32'd0);
    chk("ar_inready", 32'(bus.InReady),  32'd1);
    rst_n = 1'b1;
    bus.InValid = 1'b1;
    bus.Instr   = 16'h9ABC;
    tick();
    bus.InValid = 1'b0;
    chk("ar_post_opcode", 32'(bus.OpCode), 32'h9);
    chk("ar_post_addr",   32'(bus.AddrImm), 32'hABC);
    chk("ar_post_count",  32'(bus.Count),  32'd1);
    bus.OutReady = 1'b1;
    tick();
    bus.OutReady = 1'b0;
    chk("ar_post_empty", 32'(bus.Count), 32'd0);

`ifdef DECODER_ILLEGAL_OP_EN
    chk("il_empty0", 32'(bus.IllegalOp), 32'd0);
    bus.InValid = 1'b1;
    bus.Instr   = 16'hF123; tick();
    bus.Instr   = 16'h0456; tick();
    bus.Instr   = 16'h2789; tick();
    bus.InValid = 1'b0;
    chk("il_head0", 32'(bus.IllegalOp), 32'd1);
    bus.OutReady = 1'b1;
    tick();
    chk("il_head1", 32'(bus.IllegalOp), 32'd1);
    tick();
    chk("il_head2", 32'(bus.IllegalOp), 32'd0);
    tick();
    bus.OutReady = 1'b0;
    chk("il_empty1", 32'(bus.IllegalOp), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised successor of the single-register instruction decoder.
- Buffers fetched instructions in a DEPTH-entry FIFO with valid/ready handshakes on both sides, plus a synchronous flush.
- Presents the head instruction split into opcode, three register operand fields and an address/immediate field.
- Sits between the fetch stage and the register-file/ALU control stage.

Parameters:
- INSTR_W, 16: instruction width in bits.
- OPC_W, 4: opcode width; the opcode is the top OPC_W bits.
- FIELD_W, 4: width of each operand field (OpC, OpB, OpA). INSTR_W must equal OPC_W + 3*FIELD_W; elaboration fails otherwise.
- DEPTH, 4: queue entries; must be a power of two and at least 2.
- ILLEGAL_MASK, {2**OPC_W{1'b0}}: bit k set marks opcode k illegal. Used only with the optional feature.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- InValid  in  1  fetch presents an instruction.
- InReady  out  1  queue can accept an instruction.
- Instr  in  INSTR_W  instruction word.
- Flush  in  1  synchronous discard of all queued entries.
- OutValid  out  1  head entry is valid.
- OutReady  in  1  consumer takes the head this cycle.
- OpCode  out  OPC_W  Instr[INSTR_W-1 -: OPC_W] of the head entry.
- OpC  out  FIELD_W  next FIELD_W bits below the opcode.
- OpB  out  FIELD_W  middle field.
- OpA  out  FIELD_W  Instr[FIELD_W-1:0] of the head entry.
- AddrImm  out  INSTR_W-OPC_W  Instr[INSTR_W-OPC_W-1:0] of the head entry.
- Count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- IllegalOp  out  1  head opcode is illegal. Present only with the optional feature.

Behaviour:
- Reset (RST_N low, asynchronous):
  - Read pointer, write pointer and Count go to 0.
  - OutValid = 0, InReady = 1.
  - All field outputs are 0.
  - Storage contents need not be cleared.
- Push = InValid & InReady. Pop = OutValid & OutReady. Both are evaluated at the rising edge of CLK.
- InReady = (Count != DEPTH). It is registered-state only and has no combinational path from OutReady. When full, a pop frees the slot for the next cycle, not the current one.
- OutValid = (Count != 0).
- Latency: an instruction pushed at edge N appears on the outputs after edge N, i.e. one cycle, when the queue was empty. There is no same-cycle bypass.
- Field outputs:
  - Driven combinationally from the head storage entry, so they are registered-stable.
  - Forced to 0 while OutValid = 0.
  - They hold steady while OutValid = 1 and OutReady = 0.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop. This is legal whenever 0 < Count < DEPTH.
- Empty with push: Count goes to 1. OutReady is ignored because OutValid = 0.
- Full: Instr is ignored and no overwrite occurs.
- Flush, sampled at an edge:
  - Pointers and Count go to 0.
  - Flush overrides any push or pop in the same cycle; the incoming instruction is dropped.
  - OutValid is 0 and fields are 0 in the following cycle.
- Reset asserted mid-transfer: all entries are discarded immediately. The first edge after RST_N deasserts may accept a push.
- Ordering is strict FIFO. No entry is ever duplicated or skipped.

Optional Feature:
- Macro: DECODER_ILLEGAL_OP_EN.
- With the macro defined:
  - The IllegalOp port exists and equals OutValid & ILLEGAL_MASK[OpCode].
  - An illegal head still pops normally; the consumer decides the action.
  - Reset value of IllegalOp is 0.
- Without the macro: the port and its logic are absent, and the ILLEGAL_MASK parameter is unused.

Test Plan:
- Reset then single transfer, default params: push Instr=16'hA3C5 with OutReady=0.
  - Next cycle: OutValid=1, OpCode=4'hA, OpC=4'h3, OpB=4'hC, OpA=4'h5, AddrImm=12'h3C5, Count=1.
  - Fields hold until OutReady=1; Count then returns to 0 and the fields read 0.
- Fill and full: push 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000 back-to-back with OutReady=0.
  - After 4 pushes: Count=4, InReady=0. The fifth word is not accepted.
  - Draining yields OpCode 1,2,3,4 in order.
- Simultaneous push/pop with Count=2, held for 8 cycles: Count stays 2 and output order matches input order across pointer wrap.
- Flush: queue holds 3 entries; assert Flush together with InValid=1 and Instr=16'h7777.
  - Next cycle: Count=0, OutValid=0, fields 0.
  - 16'h7777 never appears on the outputs.
- Async reset mid-operation: with Count=3, pull RST_N low between clock edges.
  - Count=0, OutValid=0 and InReady=1 immediately, without waiting for an edge.
- DECODER_ILLEGAL_OP_EN defined, ILLEGAL_MASK=16'h8001: push 16'hF123, 16'h0456, 16'h2789.
  - IllegalOp reads 1, 1, 0 as each entry reaches the head.
  - IllegalOp is 0 when the queue is empty.
